// File: rtl/ifo_pkg.sv
// Shared types and constants for the IFFT output merger.
package ifo_pkg;

  localparam int DW      = 64;
  localparam int BEAT_CW = $clog2(65536);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2
  } ifo_state_t;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry valid/ready register buffer; ready depends only on fill level.
module axis_skid2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         srstn,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign in_rdy  = (cnt != 2'd2);
  assign out_vld = (cnt != 2'd0);
  assign out_dat = head;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_dat;
          else             tail <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // push with cnt==2 cannot happen because in_rdy is low when full
          if (cnt == 2'd1) begin
            head <= in_dat;
          end else begin
            head <= tail;
            tail <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifo_merger.sv
// Serialises IFFT streams A and B symbol by symbol onto one AXI-stream.
// Optional IFO_MERGER_TLAST_EN adds out_axi_tlst marking each symbol's last beat.
//
// state  | meaning
// IDLE   | waiting for start_level
// PASS_A | forwarding SYM_BEATS beats of stream A
// PASS_B | forwarding SYM_BEATS beats of stream B
module ifo_merger
  import ifo_pkg::*;
#(
  parameter int SYM_BEATS = 1024
) (
  input  logic          clk,
  input  logic          srstn,
  input  logic          start_level,
  output logic          ifoa_axi_trdy,
  input  logic          ifoa_axi_tvld,
  input  logic [DW-1:0] ifoa_axi_tdat,
  output logic          ifob_axi_trdy,
  input  logic          ifob_axi_tvld,
  input  logic [DW-1:0] ifob_axi_tdat,
  input  logic          out_axi_trdy,
  output logic          out_axi_tvld,
  output logic [DW-1:0] out_axi_tdat,
`ifdef IFO_MERGER_TLAST_EN
  output logic          out_axi_tlst,
`endif
  output logic [15:0]   sym_cnt,
  output logic          busy
);

`ifdef IFO_MERGER_TLAST_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(SYM_BEATS - 1);

  ifo_state_t         state;
  logic [BEAT_CW-1:0] beat_cnt;
  logic               sel_vld;
  logic [DW-1:0]      sel_dat;
  logic               skid_rdy;
  logic               accept;
  logic               last_beat;
  logic [SW-1:0]      skid_in;
  logic [SW-1:0]      skid_out;

  assign sel_vld   = (state == PASS_A) ? ifoa_axi_tvld :
                     (state == PASS_B) ? ifob_axi_tvld : 1'b0;
  assign sel_dat   = (state == PASS_B) ? ifob_axi_tdat : ifoa_axi_tdat;
  assign accept    = sel_vld & skid_rdy;
  assign last_beat = (beat_cnt == LAST_BEAT);

  assign ifoa_axi_trdy = (state == PASS_A) & skid_rdy;
  assign ifob_axi_trdy = (state == PASS_B) & skid_rdy;

`ifdef IFO_MERGER_TLAST_EN
  assign skid_in      = {last_beat, sel_dat};
  assign out_axi_tdat = skid_out[DW-1:0];
  assign out_axi_tlst = skid_out[DW];
`else
  assign skid_in      = sel_dat;
  assign out_axi_tdat = skid_out;
`endif

  axis_skid2 #(.W(SW)) u_skid (
    .clk     (clk),
    .srstn   (srstn),
    .in_vld  (sel_vld),
    .in_rdy  (skid_rdy),
    .in_dat  (skid_in),
    .out_vld (out_axi_tvld),
    .out_rdy (out_axi_trdy),
    .out_dat (skid_out)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      sym_cnt  <= 16'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (start_level) begin
            state <= PASS_A;
            busy  <= 1'b1;
          end
        end
        PASS_A: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              sym_cnt  <= sym_cnt + 16'd1;
              state    <= PASS_B;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        PASS_B: begin
          if (accept) begin
            if (last_beat) begin
              // run enable is only consulted at a pair boundary
              beat_cnt <= '0;
              sym_cnt  <= sym_cnt + 16'd1;
              state    <= start_level ? PASS_A : IDLE;
              busy     <= start_level;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifo_merger.sv
// Bench for ifo_merger with SYM_BEATS=4: directed scenarios plus random traffic
// checked against a symbol-interleaving reference queue.
module tb_ifo_merger;

  localparam int SB = 4;

  logic        clk;
  logic        srstn;
  logic        start_level;
  logic        ifoa_axi_trdy;
  logic        ifoa_axi_tvld;
  logic [63:0] ifoa_axi_tdat;
  logic        ifob_axi_trdy;
  logic        ifob_axi_tvld;
  logic [63:0] ifob_axi_tdat;
  logic        out_axi_trdy;
  logic        out_axi_tvld;
  logic [63:0] out_axi_tdat;
`ifdef IFO_MERGER_TLAST_EN
  logic        out_axi_tlst;
`endif
  logic [15:0] sym_cnt;
  logic        busy;

  ifo_merger #(.SYM_BEATS(SB)) dut (
    .clk           (clk),
    .srstn         (srstn),
    .start_level   (start_level),
    .ifoa_axi_trdy (ifoa_axi_trdy),
    .ifoa_axi_tvld (ifoa_axi_tvld),
    .ifoa_axi_tdat (ifoa_axi_tdat),
    .ifob_axi_trdy (ifob_axi_trdy),
    .ifob_axi_tvld (ifob_axi_tvld),
    .ifob_axi_tdat (ifob_axi_tdat),
    .out_axi_trdy  (out_axi_trdy),
    .out_axi_tvld  (out_axi_tvld),
    .out_axi_tdat  (out_axi_tdat),
`ifdef IFO_MERGER_TLAST_EN
    .out_axi_tlst  (out_axi_tlst),
`endif
    .sym_cnt       (sym_cnt),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] src_a[$];
  logic [63:0] src_b[$];
  logic [63:0] exp_q[$];
  int out_steps[$];
  int a_idx = 0;
  int b_idx = 0;
  int acc_total = 0;
  int out_cnt = 0;
  int step_no = 0;
  bit rnd_vld = 0;
  bit rnd_rdy = 0;
  bit stall = 0;
  logic [63:0] tdat_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: output is symbol k of A followed by symbol k of B, for each k.
  task automatic add_pair(input bit directed);
    logic [63:0] a[SB];
    logic [63:0] b[SB];
    for (int i = 0; i < SB; i++) begin
      a[i] = directed ? 64'hA0 + 64'(i) : {$urandom, $urandom};
      b[i] = directed ? 64'hB0 + 64'(i) : {$urandom, $urandom};
      src_a.push_back(a[i]);
      src_b.push_back(b[i]);
    end
    for (int i = 0; i < SB; i++) exp_q.push_back(a[i]);
    for (int i = 0; i < SB; i++) exp_q.push_back(b[i]);
  endtask

  task automatic step();
    logic [63:0] e;
    ifoa_axi_tvld = (a_idx < src_a.size()) && (!rnd_vld || $urandom_range(0, 3) != 0);
    ifoa_axi_tdat = (a_idx < src_a.size()) ? src_a[a_idx] : 64'h0;
    ifob_axi_tvld = (b_idx < src_b.size()) && (!rnd_vld || $urandom_range(0, 3) != 0);
    ifob_axi_tdat = (b_idx < src_b.size()) ? src_b[b_idx] : 64'h0;
    out_axi_trdy  = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
    #1;
    chk("sym_cnt", 64'(sym_cnt), 64'(16'(acc_total / SB)));
    if (ifoa_axi_trdy) chk("sel_a", 64'((acc_total % (2 * SB)) < SB), 64'd1);
    if (ifob_axi_trdy) chk("sel_b", 64'((acc_total % (2 * SB)) >= SB), 64'd1);
    if (out_axi_tvld && out_axi_trdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_tdat", out_axi_tdat, e);
`ifdef IFO_MERGER_TLAST_EN
        chk("out_tlst", 64'(out_axi_tlst), 64'((out_cnt % SB) == SB - 1));
`endif
        out_cnt++;
        out_steps.push_back(step_no);
      end
    end
    if (ifoa_axi_tvld && ifoa_axi_trdy) begin a_idx++; acc_total++; end
    if (ifob_axi_tvld && ifob_axi_trdy) begin b_idx++; acc_total++; end
    step_no++;
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || a_idx < src_a.size() || b_idx < src_b.size()) && g < 400) begin
      step();
      g++;
    end
    chk("drain_in_time", 64'(g < 400), 64'd1);
  endtask

  task automatic step_until_acc_mod(input int m);
    int g = 0;
    while ((acc_total % (2 * SB)) != m && g < 100) begin
      step();
      g++;
    end
    chk("reach_point", 64'(g < 100), 64'd1);
  endtask

  initial begin
    srstn = 1'b0;
    start_level = 1'b0;
    ifoa_axi_tvld = 1'b0;
    ifob_axi_tvld = 1'b0;
    ifoa_axi_tdat = '0;
    ifob_axi_tdat = '0;
    out_axi_trdy = 1'b1;
    repeat (2) @(negedge clk);
    srstn = 1'b1;

    // 1: idle with both streams valid
    ifoa_axi_tvld = 1'b1;
    ifob_axi_tvld = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_trdy_a", 64'(ifoa_axi_trdy), 64'd0);
    chk("idle_trdy_b", 64'(ifob_axi_trdy), 64'd0);
    chk("idle_tvld", 64'(out_axi_tvld), 64'd0);
    chk("idle_tdat", out_axi_tdat, 64'd0);
    chk("idle_sym", 64'(sym_cnt), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // 2: one directed pair, back-to-back output
    add_pair(1'b1);
    out_steps.delete();
    start_level = 1'b1;
    #1;
    chk("trdy_before_start", 64'(ifoa_axi_trdy), 64'd0);
    step();
    chk("first_trdy", 64'(ifoa_axi_trdy), 64'd1);
    drain();
    chk("pair_beats", 64'(out_steps.size()), 64'(2 * SB));
    if (out_steps.size() == 2 * SB)
      chk("pair_span", 64'(out_steps[2*SB-1] - out_steps[0]), 64'(2 * SB - 1));
    chk("pair_sym", 64'(sym_cnt), 64'd2);
    chk("pair_busy", 64'(busy), 64'd1);

    // 3: start_level dropped after A1 still completes the pair
    add_pair(1'b1);
    step_until_acc_mod(2);
    start_level = 1'b0;
    drain();
    repeat (3) step();
    chk("stop_busy", 64'(busy), 64'd0);
    chk("stop_trdy_a", 64'(ifoa_axi_trdy), 64'd0);
    chk("stop_trdy_b", 64'(ifob_axi_trdy), 64'd0);
    chk("stop_sym", 64'(sym_cnt), 64'd4);

    // 4: downstream stall mid-symbol
    start_level = 1'b1;
    add_pair(1'b0);
    step_until_acc_mod(1);
    stall = 1'b1;
    step();
    tdat_hold = out_axi_tdat;
    repeat (4) begin
      step();
      chk("stall_tdat", out_axi_tdat, tdat_hold);
      chk("stall_tvld", 64'(out_axi_tvld), 64'd1);
    end
    chk("stall_buffered", 64'(acc_total - out_cnt), 64'd2);
    chk("stall_trdy", 64'(ifoa_axi_trdy), 64'd0);
    stall = 1'b0;
    drain();

    // 5: random valid/ready over three pairs
    rnd_vld = 1'b1;
    rnd_rdy = 1'b1;
    repeat (3) add_pair(1'b0);
    drain();
    rnd_vld = 1'b0;
    rnd_rdy = 1'b0;

    // 6: reset in the middle of symbol B, then restart
    add_pair(1'b0);
    step_until_acc_mod(SB + 2);
    srstn = 1'b0;
    #1;
    chk("rst_trdy_a", 64'(ifoa_axi_trdy), 64'd0);
    chk("rst_trdy_b", 64'(ifob_axi_trdy), 64'd0);
    chk("rst_tvld", 64'(out_axi_tvld), 64'd0);
    chk("rst_tdat", out_axi_tdat, 64'd0);
    chk("rst_sym", 64'(sym_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    src_a.delete();
    src_b.delete();
    exp_q.delete();
    a_idx = 0;
    b_idx = 0;
    acc_total = 0;
    out_cnt = 0;
    @(negedge clk);
    repeat (2) step();
    srstn = 1'b1;
    add_pair(1'b1);
    drain();
    chk("restart_sym", 64'(sym_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifo_merger.md
# ifo_merger

Downstream neighbour of the subcarrier mapper and its two IFFT instances. Consumes the two IFFT output streams (A and B), serialises them symbol by symbol (A then B) onto one 64-bit AXI-stream toward the transmit path, and registers the output through a 2-entry skid buffer. Operation is gated by the same `start_level` that enables the mapper, so the pair stays aligned by construction.

## Interface
- `SYM_BEATS`, 1024: beats per IFFT symbol per stream (64-bit beat = two 32-bit I/Q samples); legal range 2..65535.
- `DW`, 64: data width; fixed at 64 in this design.
- `clk` in 1: single clock.
- `srstn` in 1: asynchronous, active-low reset.
- `start_level` in 1: run enable, level-sensitive.
- `ifoa_axi_trdy` out 1: ready to IFFT A.
- `ifoa_axi_tvld` in 1: valid from IFFT A.
- `ifoa_axi_tdat` in 64: data from IFFT A.
- `ifob_axi_trdy` out 1: ready to IFFT B.
- `ifob_axi_tvld` in 1: valid from IFFT B.
- `ifob_axi_tdat` in 64: data from IFFT B.
- `out_axi_trdy` in 1: downstream ready.
- `out_axi_tvld` out 1: output valid.
- `out_axi_tdat` out 64: output data.
- `sym_cnt` out 16: completed symbols (A and B each count), wraps 65535->0.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, PASS_A, PASS_B.
- IDLE -> PASS_A when `start_level`=1 (sampled at rising edge).
- PASS_A: forward IFFT A beats; beat counter increments on each accepted A beat; on the SYM_BEATS-th accept -> PASS_B, counter cleared, `sym_cnt`+1.
- PASS_B: same for stream B; on the last accept `sym_cnt`+1, then -> PASS_A if `start_level`=1, else IDLE.
- `start_level` falling mid-symbol has no immediate effect: the current A/B pair completes, then IDLE. A symbol is never truncated.
- Only the selected stream sees `trdy`; the other stream's `trdy` is 0 even if its `tvld`=1. Both streams valid at the same time is normal; the non-selected stream is held off.
- `ifoX_axi_trdy` = (state selects X) AND skid buffer not full. It is a registered-state function and carries no combinational path from `out_axi_trdy`.
- Data passes unmodified; no arithmetic on samples.
- The skid buffer never drops or reorders beats.

## Timing
- Reset values: all `trdy`=0, `out_axi_tvld`=0, `out_axi_tdat`=0, `sym_cnt`=0, `busy`=0, state IDLE, buffer empty.
- Asynchronous reset mid-symbol discards buffered beats and counters immediately. After release, operation resumes from IDLE.
- First `trdy` goes high the cycle after `start_level` is sampled high.
- Latency: a beat accepted in cycle n drives `out_axi_tvld` in cycle n+1 when the buffer is empty.
- Throughput: 1 beat/cycle with `out_axi_trdy` held at 1, including across the A->B and B->A switches. There is no bubble at a symbol boundary.
- Buffer full (2 entries) forces the selected `trdy` to 0 the next cycle. While `out_axi_tvld`=1 and `out_axi_trdy`=0, `out_axi_tdat` stays stable.
- Simultaneous push and pop while full: pop is honoured, push is blocked by `trdy`=0, so there is no overflow.
- `sym_cnt` and `busy` are registered and update the cycle after the causing handshake.

## Configuration
- `IFO_MERGER_TLAST_EN` defined: adds port `out_axi_tlst` (out, 1). It is high with the last beat of each symbol (beat SYM_BEATS of A, and of B) and travels through the skid buffer alongside the data.
- Not defined: the port is absent and the buffer carries only 64 bits.

## Structure
- Package `ifo_pkg`: FSM state enum, `DW` constant, beat-counter width = $clog2(65536) = 16.
- Sub-module `axis_skid2`: 2-entry valid/ready register buffer with width parameter (64 or 65 bits). Reusable elsewhere on the transmit path.
- Top holds the FSM, counters and input muxing.

## Test plan
All scenarios use `SYM_BEATS`=4.
- Reset, then hold `start_level`=0 with both streams valid -> both `trdy`=0, `out_axi_tvld`=0, `sym_cnt`=0.
- `start_level`=1; A sends 0xA0..0xA3, B sends 0xB0..0xB3; out ready -> output is A0,A1,A2,A3,B0,B1,B2,B3 on 8 consecutive cycles, `sym_cnt`=2.
- Same as the previous scenario, but drop `start_level` after beat A1 -> full pair is emitted, then IDLE; `busy`=0 and no further `trdy`.
- Hold `out_axi_trdy`=0 for 5 cycles mid-symbol -> exactly 2 beats buffered, `trdy`=0, `tdat` stable; on release, order is preserved.
- Assert `srstn`=0 mid-symbol B -> outputs return to reset values immediately; after restart, output begins with A beat 0.
- With `IFO_MERGER_TLAST_EN`: `out_axi_tlst`=1 only on A3 and B3.
